// File: rtl/mds_pkg.sv
// Shared constants and types for the serial Twofish MDS engine.
package mds_pkg;

    localparam int BYTE_W = 8;
    localparam int WORD_W = 32;

    localparam logic [8:0] MDS_POLY = 9'h169;

    // Rows z0..z3, columns y0..y3
    localparam logic [BYTE_W-1:0] MDS_COEF [0:3][0:3] = '{
        '{8'h01, 8'hEF, 8'h5B, 8'h5B},
        '{8'h5B, 8'hEF, 8'hEF, 8'h01},
        '{8'hEF, 8'h5B, 8'h01, 8'hEF},
        '{8'hEF, 8'h01, 8'hEF, 8'h5B}
    };

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

endpackage

// File: rtl/gf256_mul.sv
// Combinational GF(2^8) multiplier, shift-and-reduce modulo POLY.
module gf256_mul
    import mds_pkg::*;
#(
    parameter logic [8:0] POLY = MDS_POLY
) (
    input  logic [BYTE_W-1:0] a,
    input  logic [BYTE_W-1:0] b,
    output logic [BYTE_W-1:0] p
);

    logic [BYTE_W-1:0] t;

    always_comb begin
        p = '0;
        t = a;
        for (int i = 0; i < BYTE_W; i++) begin
            if (b[i]) p = p ^ t;
            t = {t[BYTE_W-2:0], 1'b0} ^ (t[BYTE_W-1] ? POLY[BYTE_W-1:0] : '0);
        end
    end

endmodule

// File: rtl/mds_serial_ctrl.sv
// Iterative Twofish MDS engine: LANES GF multipliers time-shared over 16 products.
// Optional MDS_SERIAL_OVERLAP_EN lets DONE hand off directly to a new word.
//
// state | meaning
// IDLE  | waiting for Y, in_ready high
// CALC  | accumulating products indexed by cnt
// DONE  | Z presented on out_z until out_ready
module mds_serial_ctrl
    import mds_pkg::*;
#(
    parameter int         LANES = 1,
    parameter logic [8:0] POLY  = MDS_POLY
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_y,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_z,
    output logic              busy
);

    generate
        if (!(LANES == 1 || LANES == 4)) begin : g_bad_lanes
            $error("mds_serial_ctrl: LANES must be 1 or 4");
        end
    endgenerate

    state_t            state, state_nxt;
    logic [WORD_W-1:0] y_reg;
    logic [3:0]        cnt;
    logic [BYTE_W-1:0] acc     [0:3];
    logic [BYTE_W-1:0] acc_fin [0:3];
    logic [BYTE_W-1:0] y_b     [0:3];
    logic [1:0]        col     [0:LANES-1];
    logic [BYTE_W-1:0] coef    [0:LANES-1];
    logic [BYTE_W-1:0] prod    [0:LANES-1];
    logic [BYTE_W-1:0] row_x;
    logic [1:0]        row;
    logic              last;
    logic              accept;

    assign y_b[0] = y_reg[31:24];
    assign y_b[1] = y_reg[23:16];
    assign y_b[2] = y_reg[15:8];
    assign y_b[3] = y_reg[7:0];

    assign row  = cnt[3:2];
    assign last = (cnt == 4'(16 - LANES));

    // With LANES=4 cnt[1:0] stays 0, so lane l always takes column l
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign col[l]  = cnt[1:0] + 2'(l);
        assign coef[l] = MDS_COEF[row][col[l]];
        gf256_mul #(.POLY(POLY)) u_mul (
            .a(coef[l]),
            .b(y_b[col[l]]),
            .p(prod[l])
        );
    end

    always_comb begin
        row_x = '0;
        for (int l = 0; l < LANES; l++) row_x = row_x ^ prod[l];
    end

    always_comb begin
        for (int r = 0; r < 4; r++)
            acc_fin[r] = acc[r] ^ ((2'(r) == row) ? row_x : '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = rst_n;
                if (in_valid) state_nxt = CALC;
            end
            CALC: begin
                busy = 1'b1;
                if (last) state_nxt = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
`ifdef MDS_SERIAL_OVERLAP_EN
                in_ready = out_ready;
                if (out_ready) state_nxt = in_valid ? CALC : IDLE;
`else
                if (out_ready) state_nxt = IDLE;
`endif
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign accept = in_ready & in_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_reg <= '0;
            cnt   <= '0;
            out_z <= '0;
            for (int r = 0; r < 4; r++) acc[r] <= '0;
        end else if (accept) begin
            y_reg <= in_y;
            cnt   <= '0;
            for (int r = 0; r < 4; r++) acc[r] <= '0;
        end else if (state == CALC) begin
            acc[row] <= acc_fin[row];
            if (last) out_z <= {acc_fin[0], acc_fin[1], acc_fin[2], acc_fin[3]};
            else      cnt   <= cnt + 4'(LANES);
        end
    end

endmodule

// File: tb/tb_mds_serial_ctrl.sv
// Self-checking bench for mds_serial_ctrl: directed vectors, back-pressure,
// async abort, random traffic and handoff spacing against a behavioural model.
module tb_mds_serial_ctrl;

    localparam int LANES = 1;
    localparam int LAT   = (LANES == 1) ? 17 : 5;
`ifdef MDS_SERIAL_OVERLAP_EN
    localparam bit OVL = 1'b1;
`else
    localparam bit OVL = 1'b0;
`endif
    localparam int SPACING = OVL ? LAT : LAT + 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_y;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_z;
    logic        busy;

    mds_serial_ctrl #(.LANES(LANES)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_y(in_y),
        .out_valid(out_valid), .out_ready(out_ready), .out_z(out_z),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [14:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (15'(a) << i);
        for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (15'(9'h169) << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic [31:0] mds_ref(input logic [31:0] y);
        logic [7:0] c [0:3][0:3];
        logic [7:0] yb [0:3];
        logic [31:0] z;
        c = '{'{8'h01, 8'hEF, 8'h5B, 8'h5B}, '{8'h5B, 8'hEF, 8'hEF, 8'h01},
              '{8'hEF, 8'h5B, 8'h01, 8'hEF}, '{8'hEF, 8'h01, 8'hEF, 8'h5B}};
        for (int k = 0; k < 4; k++) yb[k] = y[31 - 8*k -: 8];
        z = '0;
        for (int r = 0; r < 4; r++)
            for (int k = 0; k < 4; k++)
                z[31 - 8*r -: 8] = z[31 - 8*r -: 8] ^ gmul(c[r][k], yb[k]);
        return z;
    endfunction

    // Model: whether a word is in flight, cycles since acceptance, its result,
    // and the value out_z should currently show.
    bit          m_busy = 0;
    int          m_t = 0;
    logic [31:0] m_z = '0;
    logic [31:0] m_zreg = '0;
    bit          last_acc = 0;
    int          cyc = 0;
    int          dut_acc [$];

    always @(negedge clk) begin
        bit e_done, e_rdy, acc, fire;
        cyc++;
        if (!rst_n) begin
            chk(in_ready == 1'b0, "rst in_ready", 32'(in_ready), 32'h0);
            chk(out_valid == 1'b0, "rst out_valid", 32'(out_valid), 32'h0);
            chk(busy == 1'b0, "rst busy", 32'(busy), 32'h0);
            chk(out_z == 32'h0, "rst out_z", out_z, 32'h0);
            m_busy = 0; m_t = 0; m_zreg = '0; last_acc = 0;
        end else begin
            e_done = m_busy && (m_t >= LAT);
            e_rdy  = !m_busy || (OVL && e_done && out_ready);
            chk(in_ready === e_rdy, "in_ready", 32'(in_ready), 32'(e_rdy));
            chk(out_valid === e_done, "out_valid", 32'(out_valid), 32'(e_done));
            chk(busy === m_busy, "busy", 32'(busy), 32'(m_busy));
            chk(out_z === m_zreg, "out_z", out_z, m_zreg);
            if (in_ready && in_valid) dut_acc.push_back(cyc);
            acc  = e_rdy && in_valid;
            fire = e_done && out_ready;
            last_acc = acc;
            if (acc) begin
                m_busy = 1; m_t = 1; m_z = mds_ref(in_y);
            end else if (fire) begin
                m_busy = 0;
            end else if (m_busy && m_t < LAT) begin
                m_t++;
                if (m_t == LAT) m_zreg = m_z;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_accept(input string name);
        int n;
        n = 0;
        while (1) begin
            @(posedge clk); #1;
            if (last_acc) break;
            if (++n > 60) begin chk(1'b0, {name, " accept timeout"}, 32'(n), 32'h0); break; end
        end
    endtask

    task automatic xfer(input logic [31:0] y, input logic [31:0] exp, input int hold);
        int k;
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_y = y;
        wait_accept("xfer");
        in_valid = 1'b0;
        in_y = $urandom;
        k = 1;
        while (!out_valid && k < 60) begin
            @(posedge clk); #1;
            k++;
            in_y = $urandom;
        end
        chk(k == LAT, "latency", 32'(k), 32'(LAT));
        chk(out_z === exp, "result literal", out_z, exp);
        if (hold > 0) begin
            in_valid = 1'b1;
            in_y = ~y;
            repeat (hold) begin @(posedge clk); #1; end
            chk(out_z === exp, "held result", out_z, exp);
            in_valid = 1'b0;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk(out_valid == 1'b0, "one transfer", 32'(out_valid), 32'h0);
        chk(in_ready == 1'b1, "back to idle", 32'(in_ready), 32'h1);
    endtask

    logic [31:0] vy [0:5] = '{32'h01000000, 32'h00000001, 32'h00010000,
                              32'h00000000, 32'h02000000, 32'h01000001};
    logic [31:0] vz [0:5] = '{32'h015BEFEF, 32'h5B01EF5B, 32'hEFEF5B01,
                              32'h00000000, 32'h02B6B7B7, 32'h5A5A00B4};

    initial begin
        int n;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_y = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) xfer(vy[i], vz[i], 0);

        // back-pressure, in_valid held high during DONE must be ignored
        xfer(32'h00000100, 32'h5BEF01EF, 10);

        // async abort in the middle of CALC (cnt=7)
        in_valid = 1'b1; in_y = 32'h00000010;
        wait_accept("abort");
        in_valid = 1'b0;
        n = 0;
        while (m_t != 8 && n < 40) begin @(posedge clk); #1; n++; end
        #2 rst_n = 1'b0;
        #1;
        chk(out_valid == 1'b0, "abort out_valid", 32'(out_valid), 32'h0);
        chk(busy == 1'b0, "abort busy", 32'(busy), 32'h0);
        chk(out_z == 32'h0, "abort out_z", out_z, 32'h0);
        chk(in_ready == 1'b0, "abort in_ready", 32'(in_ready), 32'h0);
        @(posedge clk); #1 rst_n = 1'b1;
        xfer(32'h00000001, 32'h5B01EF5B, 0);

        // random traffic; producer holds in_valid/in_y until accepted
        repeat (700) begin
            @(posedge clk); #1;
            if (!in_valid || last_acc) begin
                in_valid = ($urandom_range(0, 2) != 0);
                in_y = $urandom;
            end
            out_ready = ($urandom_range(0, 3) != 0);
        end

        in_valid = 1'b0; out_ready = 1'b1;
        repeat (LAT + 4) @(posedge clk);
        #1;

        // continuous in_valid with out_ready high: acceptance spacing
        dut_acc.delete();
        in_valid = 1'b1; in_y = $urandom;
        repeat (5 * SPACING) begin
            @(posedge clk); #1;
            if (last_acc) in_y = $urandom;
        end
        in_valid = 1'b0;
        chk(dut_acc.size() >= 4, "spacing samples", 32'(dut_acc.size()), 32'h4);
        for (int i = 1; i < dut_acc.size(); i++)
            chk(dut_acc[i] - dut_acc[i-1] == SPACING, "accept spacing",
                32'(dut_acc[i] - dut_acc[i-1]), 32'(SPACING));

        repeat (LAT + 4) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
